// File: rtl/set_mode_controller.sv
// set_mode_controller: clock field-select FSM with key edge detection,
// increment auto-repeat, field blink and inactivity timeout back to run.
module set_mode_controller #(
   parameter int TIMEOUT_TICKS = 10,
   parameter int HOLD_TICKS = 2
) (
   input  logic       clk,
   input  logic       cr,
   input  logic       tick,
   input  logic       key_mode,
   input  logic       key_inc,
   output logic [1:0] clock_set_select,
   output logic       set_confirm,
   output logic       blink,
   output logic       timeout
);
   localparam int HW = $clog2(HOLD_TICKS + 2);
   localparam int IW = $clog2(TIMEOUT_TICKS + 2);
   localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);
   localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_TICKS);
   localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_TICKS - 1);
   typedef enum logic [1:0] {RUN = 2'b00, SET_SEC = 2'b01, SET_MIN = 2'b10, SET_HOUR = 2'b11} state_t;
   state_t state, state_n;
   logic mode_q, inc_q;
   logic [HW-1:0] hold_cnt, hold_n;
   logic [IW-1:0] idle_cnt, idle_n;
   logic confirm_n, blink_n, timeout_n;
   logic mode_edge, inc_edge, in_set, repeat_fire, expire, change;
   always_comb begin
      mode_edge = key_mode & ~mode_q;
      inc_edge = key_inc & ~inc_q;
      in_set = state != RUN;
      repeat_fire = in_set & key_inc & ~inc_edge & tick & (hold_cnt == HOLD_MAX);
      // any key activity or a repeat strobe on the final idle tick cancels the timeout
      expire = in_set & tick & (idle_cnt == IDLE_LAST) & ~mode_edge & ~inc_edge & ~repeat_fire;
      state_n = mode_edge ? state_t'(state + 2'd1) : expire ? RUN : state;
      change = state_n != state;
      confirm_n = in_set & ~mode_edge & (inc_edge | repeat_fire);
      timeout_n = expire;
      blink_n = (change | ~in_set) ? 1'b0 : blink ^ tick;
      hold_n = (change | ~in_set | ~key_inc | inc_edge) ? '0 :
               (tick && hold_cnt != HOLD_MAX) ? hold_cnt + 1'b1 : hold_cnt;
      idle_n = (change | ~in_set | mode_edge | inc_edge | set_confirm) ? '0 :
               (tick && idle_cnt != IDLE_MAX) ? idle_cnt + 1'b1 : idle_cnt;
   end
   always_ff @(posedge clk) begin
      mode_q <= key_mode;
      inc_q <= key_inc;
      if (!cr) begin
         state <= RUN;
         set_confirm <= 1'b0;
         blink <= 1'b0;
         timeout <= 1'b0;
         hold_cnt <= '0;
         idle_cnt <= '0;
      end else begin
         state <= state_n;
         set_confirm <= confirm_n;
         blink <= blink_n;
         timeout <= timeout_n;
         hold_cnt <= hold_n;
         idle_cnt <= idle_n;
      end
   end
   assign clock_set_select = state;
endmodule

// File: tb/tb_set_mode_controller.sv
// tb_set_mode_controller: directed scenarios plus randomized key/tick traffic,
// checked every cycle against a behavioural model of the set-mode rules.
module tb_set_mode_controller;
   localparam int T = 10;
   localparam int H = 2;
   logic clk = 1'b0;
   logic cr = 1'b0;
   logic tick = 1'b0;
   logic key_mode = 1'b0;
   logic key_inc = 1'b0;
   logic [1:0] clock_set_select;
   logic set_confirm, blink, timeout;
   int checks = 0;
   int errors = 0;
   int m_st = 0, m_hold = 0, m_idle = 0;
   bit m_conf = 0, m_blink = 0, m_to = 0, pm = 0, pi = 0;

   set_mode_controller #(.TIMEOUT_TICKS(T), .HOLD_TICKS(H)) dut (
      .clk(clk), .cr(cr), .tick(tick), .key_mode(key_mode), .key_inc(key_inc),
      .clock_set_select(clock_set_select), .set_confirm(set_confirm),
      .blink(blink), .timeout(timeout)
   );

   always #5 clk = ~clk;

   // reference: field index 0..3, tick counts since last activity / since the press began
   always @(posedge clk) begin
      bit me, ie, rep, mv;
      int nst;
      me = key_mode && !pm;
      ie = key_inc && !pi;
      pm = key_mode;
      pi = key_inc;
      if (!cr) begin
         m_st = 0; m_conf = 0; m_blink = 0; m_to = 0; m_hold = 0; m_idle = 0;
      end else begin
         rep = m_st != 0 && key_inc && !ie && tick && m_hold == H;
         nst = me ? (m_st + 1) % 4 : m_st;
         m_to = m_st != 0 && !me && !ie && !rep && tick && m_idle == T - 1;
         if (m_to) nst = 0;
         mv = nst != m_st;
         m_blink = (mv || m_st == 0) ? 0 : (tick ? !m_blink : m_blink);
         m_hold = (mv || m_st == 0 || !key_inc || ie) ? 0 : (tick && m_hold < H) ? m_hold + 1 : m_hold;
         m_idle = (mv || m_st == 0 || me || ie || m_conf) ? 0 : (tick && m_idle < T) ? m_idle + 1 : m_idle;
         m_conf = m_st != 0 && !me && (ie || rep);
         m_st = nst;
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      #1;
      chk("model_sel", int'(clock_set_select), m_st);
      chk("model_confirm", int'(set_confirm), int'(m_conf));
      chk("model_blink", int'(blink), int'(m_blink));
      chk("model_timeout", int'(timeout), int'(m_to));
   end

   task automatic drive(input logic m, input logic i, input logic t);
      key_mode = m;
      key_inc = i;
      tick = t;
      @(negedge clk);
   endtask

   initial begin
      int pulses;
      bit quiet;
      @(negedge clk);
      drive(0, 0, 0);
      drive(0, 0, 1);
      chk("rst_sel", int'(clock_set_select), 0);
      chk("rst_confirm", int'(set_confirm), 0);
      chk("rst_blink", int'(blink), 0);
      chk("rst_timeout", int'(timeout), 0);
      cr = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         drive(1, 0, 0);
         chk("mode_cycle_sel", int'(clock_set_select), k % 4);
         chk("mode_cycle_confirm", int'(set_confirm), 0);
         drive(0, 0, 0);
      end
      drive(0, 1, 0);
      chk("run_inc_confirm", int'(set_confirm), 0);
      drive(0, 0, 0);
      chk("run_inc_confirm2", int'(set_confirm), 0);
      chk("run_inc_sel", int'(clock_set_select), 0);
      repeat (2) begin drive(1, 0, 0); drive(0, 0, 0); end
      chk("min_sel", int'(clock_set_select), 2);
      drive(0, 1, 0);
      chk("min_inc_pulse", int'(set_confirm), 1);
      drive(0, 1, 0);
      chk("min_inc_single", int'(set_confirm), 0);
      drive(0, 0, 0);
      drive(1, 0, 0);
      chk("hour_sel", int'(clock_set_select), 3);
      drive(0, 0, 0);
      pulses = 0;
      drive(0, 1, 0);
      pulses += int'(set_confirm);
      for (int k = 0; k < 6; k++) begin
         drive(0, 1, 0); pulses += int'(set_confirm);
         drive(0, 1, 0); pulses += int'(set_confirm);
         drive(0, 1, 1); pulses += int'(set_confirm);
      end
      chk("repeat_pulses", pulses, 5);
      pulses = 0;
      drive(0, 0, 0); pulses += int'(set_confirm);
      repeat (3) begin drive(0, 0, 1); pulses += int'(set_confirm); end
      chk("release_pulses", pulses, 0);
      drive(1, 0, 0);
      chk("hour_to_run", int'(clock_set_select), 0);
      drive(0, 0, 0);
      drive(1, 0, 0);
      chk("sec_sel", int'(clock_set_select), 1);
      drive(0, 0, 0);
      repeat (9) begin drive(0, 0, 1); drive(0, 0, 0); end
      chk("pre_timeout_sel", int'(clock_set_select), 1);
      chk("pre_timeout_to", int'(timeout), 0);
      drive(0, 0, 1);
      chk("timeout_sel", int'(clock_set_select), 0);
      chk("timeout_pulse", int'(timeout), 1);
      chk("timeout_blink", int'(blink), 0);
      drive(0, 0, 0);
      chk("timeout_single", int'(timeout), 0);
      drive(1, 0, 0);
      drive(0, 0, 0);
      repeat (9) begin drive(0, 0, 1); drive(0, 0, 0); end
      drive(0, 1, 1);
      chk("edge_beats_timeout_sel", int'(clock_set_select), 1);
      chk("edge_beats_timeout_conf", int'(set_confirm), 1);
      chk("edge_beats_timeout_to", int'(timeout), 0);
      drive(0, 0, 0);
      drive(1, 1, 0);
      chk("both_edges_sel", int'(clock_set_select), 2);
      chk("both_edges_conf", int'(set_confirm), 0);
      drive(0, 0, 0);
      drive(0, 1, 0);
      repeat (3) begin drive(0, 1, 1); drive(0, 1, 0); end
      cr = 1'b0;
      drive(1, 1, 1);
      chk("mid_repeat_rst_sel", int'(clock_set_select), 0);
      chk("mid_repeat_rst_conf", int'(set_confirm), 0);
      chk("mid_repeat_rst_blink", int'(blink), 0);
      chk("mid_repeat_rst_to", int'(timeout), 0);
      cr = 1'b1;
      drive(1, 1, 0);
      chk("held_mode_no_edge", int'(clock_set_select), 0);
      drive(1, 1, 1);
      chk("held_inc_no_conf", int'(set_confirm), 0);
      chk("held_mode_no_edge2", int'(clock_set_select), 0);
      for (int i = 0; i < 4000; i++) begin
         quiet = ((i / 500) % 2) == 1;
         cr = $urandom_range(0, 249) != 0;
         if ($urandom_range(0, quiet ? 80 : 7) == 0) key_mode = ~key_mode;
         if ($urandom_range(0, quiet ? 60 : 9) == 0) key_inc = ~key_inc;
         tick = $urandom_range(0, 2) == 0;
         @(negedge clk);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/set_mode_controller.md
SET_MODE_CONTROLLER -- requirements
Module: set_mode_controller

Interface
REQ-001 Parameter: TIMEOUT_TICKS, 10, idle ticks in a set state before automatic return to run.
REQ-002 Parameter: HOLD_TICKS, 2, ticks key_inc must be held before auto-repeat starts.
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 cr  input  1  reset; synchronous, active-low.
REQ-005 tick  input  1  one-cycle timebase pulse (1 Hz nominal); timing reference for blink, timeout and repeat.
REQ-006 key_mode  input  1  debounced mode key level; active-high.
REQ-007 key_inc  input  1  debounced increment key level; active-high.
REQ-008 clock_set_select  output  2  field selection: 00 run, 01 second, 10 minute, 11 hour.
REQ-009 set_confirm  output  1  single-cycle increment/clear strobe for the selected field.
REQ-010 blink  output  1  display-blank enable for the selected field.
REQ-011 timeout  output  1  single-cycle pulse when a set state is abandoned by inactivity.

Function
REQ-012 The module SHALL register both keys each cycle; edge = current level high and previous sample low.
REQ-013 FSM states SHALL be RUN(00), SET_SEC(01), SET_MIN(10), SET_HOUR(11); clock_set_select SHALL be the registered state code.
REQ-014 A key_mode edge SHALL advance RUN->SET_SEC->SET_MIN->SET_HOUR->RUN; the new state is visible the cycle after the edge cycle.
REQ-015 A key_inc edge in any set state SHALL make set_confirm high for exactly the next cycle.
REQ-016 set_confirm SHALL never assert in RUN; key_inc activity in RUN SHALL have no effect on any output.
REQ-017 Simultaneous key_mode and key_inc edges SHALL advance the state and suppress set_confirm.
REQ-018 Hold counter SHALL clear on a key_inc edge, on key_inc low and on any state change, and SHALL count ticks while key_inc is high in a set state, saturating at HOLD_TICKS.
REQ-019 With hold counter saturated, each tick while key_inc is still high SHALL produce one set_confirm pulse (auto-repeat), at most one pulse per tick.
REQ-020 Idle counter SHALL clear on any key edge, any set_confirm pulse and any state change, and SHALL count ticks in set states only.
REQ-021 A tick arriving with idle count = TIMEOUT_TICKS-1 SHALL move the FSM to RUN and pulse timeout for one cycle; a key edge in that same cycle SHALL take priority (counter cleared, no timeout, key acted on).
REQ-022 blink SHALL toggle on each tick in set states, be 0 in RUN, and clear to 0 on every state change.
REQ-023 Counters SHALL be sized to hold their parameter value with no wrap; saturation is required behaviour.

Reset
REQ-024 When cr=0 at a rising clk edge: state RUN, clock_set_select=00, set_confirm=0, blink=0, timeout=0, both counters 0, key samples loaded with the current key levels (a key held through reset SHALL NOT produce an edge).
REQ-025 Reset SHALL override every other input, including in mid-set or mid-repeat.

Verification
REQ-026 Reset release, four key_mode presses -> clock_set_select 01,10,11,00 in order, each one cycle after its edge; set_confirm stays 0.
REQ-027 In SET_MIN, single key_inc press -> exactly one set_confirm cycle, the cycle after the edge; key_inc press in RUN -> no set_confirm.
REQ-028 In SET_HOUR, hold key_inc for 6 ticks -> one edge pulse, then one pulse on each of ticks 3..6 (5 pulses total); release -> pulses stop.
REQ-029 Enter SET_SEC, no keys for 10 ticks -> on 10th tick state returns to 00, timeout pulses once, blink=0; repeat with key_inc edge on 10th tick -> stays 01, set_confirm pulses, no timeout.
REQ-030 key_mode and key_inc rising in the same cycle while in SET_SEC -> state 10, no set_confirm; cr=0 during auto-repeat -> all outputs 0 next cycle, held keys produce no edge after release of reset.
